// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding,
// instruction step sizes and a helper that picks the step for an alignment.
package pc_unit_pkg;

  // Encoding of the next_sel input
  typedef enum logic [1:0] {
    PC_NEXT_SEQ = 2'b00,  // pc + step
    PC_NEXT_REL = 2'b01,  // pc + imm
    PC_NEXT_RAS = 2'b10,  // return-address-stack top
    PC_NEXT_REG = 2'b11   // rs1 + imm, bit 0 cleared
  } pc_next_e;

  // Sequential step in bytes for each instruction alignment
  localparam int PC_STEP_IALIGN32 = 4;
  localparam int PC_STEP_IALIGN16 = 2;

  // Step size for a given instruction alignment in bits
  function automatic int pc_step_for(input int ialign);
    return (ialign == 16) ? PC_STEP_IALIGN16 : PC_STEP_IALIGN32;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer addressed by a top pointer with a
// saturating entry count. When full, a push wraps onto the oldest entry.
// A push together with a pop on a non-empty stack replaces the top entry.
import pc_unit_pkg::*;

module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic            empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  entries [DEPTH];
  logic [PTR_W-1:0] top;
  logic [CNT_W-1:0] count;
  logic             pop_ok;
  logic [PTR_W-1:0] wr_idx;

  assign empty    = (count == '0);
  assign pop_ok   = pop & ~empty;
  assign top_data = entries[top];

  // A replacing push writes the current top; a plain push writes the next slot
  always_comb begin
    wr_idx = top + 1'b1;
    if (pop_ok) wr_idx = top;
  end

  // Top pointer and entry count; pop on an empty stack is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top   <= '0;
      count <= '0;
    end else if (push && pop_ok) begin
      top   <= top;
      count <= count;
    end else if (push) begin
      top <= top + 1'b1;
      if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
    end else if (pop_ok) begin
      top   <= top - 1'b1;
      count <= count - 1'b1;
    end
  end

  // Entry storage carries no reset; the count alone defines validity
  always_ff @(posedge clk) begin
    if (push) entries[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: selects the next PC, rejects misaligned targets with
// a one-cycle error pulse, handles flush redirects and (optionally) a
// return-address stack. Define PC_UNIT_RAS_EN to build the RAS in; without
// it ras_push/ras_pop are ignored, ras_empty is 1 and next_sel=10 acts as 00.
import pc_unit_pkg::*;

module pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4,
  parameter int              IALIGN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      next_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc_out,
  output logic            misalign_err,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] STEP = XLEN'(pc_step_for(IALIGN));

  logic [XLEN-1:0] pc_q;
  logic            err_q;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] reg_pc;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] target;
  logic            misaligned;

  assign pc_out       = pc_q;
  assign misalign_err = err_q;

  assign seq_pc = pc_q + STEP;
  assign rel_pc = pc_q + imm;
  assign reg_pc = (rs1 + imm) & ~XLEN'(1);

`ifdef PC_UNIT_RAS_EN
  logic ras_act_push;
  logic ras_act_pop;

  assign ras_act_push = ras_push & en & ~flush;
  assign ras_act_pop  = ras_pop  & en & ~flush;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_act_push),
    .pop       (ras_act_pop),
    .push_data (seq_pc),
    .top_data  (ras_top),
    .empty     (ras_empty)
  );
`else
  localparam int ras_depth_unused = RAS_DEPTH;
  logic ras_req_unused;

  assign ras_req_unused = ras_push ^ ras_pop;
  assign ras_top        = seq_pc;
  assign ras_empty      = 1'b1;
`endif

  // Next-PC target selection; an empty RAS falls back to the sequential PC
  always_comb begin
    target = seq_pc;
    unique case (pc_next_e'(next_sel))
      PC_NEXT_SEQ: target = seq_pc;
      PC_NEXT_REL: target = rel_pc;
      PC_NEXT_RAS: target = ras_empty ? seq_pc : ras_top;
      PC_NEXT_REG: target = reg_pc;
      default:     target = seq_pc;
    endcase
  end

  // Only 16-bit alignment tolerates bit 1 set in a target
  assign misaligned = (IALIGN == 32) && target[1];

  // PC register and error pulse: flush beats misalign reject beats normal update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else if (flush) begin
      pc_q  <= flush_pc;
      err_q <= 1'b0;
    end else if (en && misaligned) begin
      err_q <= 1'b1;
    end else if (en) begin
      pc_q  <= target;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
    end
  end

endmodule
